// File: rtl/mem_miss_sequencer.sv
// mem_miss_sequencer: MEM-stage cache/memory miss sequencer (IDLE/WB/FILL/RESOLVE); `define MEM_MISS_PERF_EN adds hit/miss/wb counters
module mem_miss_sequencer #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  input logic req_valid,
  input logic req_write,
  input logic req_is_word,
  input logic cache_hit,
  input logic cache_dirty,
  output logic we_cache,
  output logic cache_input_type,
  output logic set_valid,
  output logic set_dirty,
  output logic we_memory,
  output logic memory_address_type,
  output logic is_word,
  output logic register_write,
  output logic lock,
  output logic pc_enable,
  output logic busy,
`ifdef MEM_MISS_PERF_EN
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
`endif
  output logic err
);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [LW-1:0] LAT = LW'(MEM_LATENCY);
  typedef enum logic [1:0] {IDLE, WB, FILL, RESOLVE} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] lat_cnt, lat_nxt;
  logic wr_q, word_q, hit, miss, done, acc, acc_wr, store_we, fill_we;
  assign hit = req_valid && cache_hit;
  assign miss = req_valid && !cache_hit;
  assign done = lat_cnt == LAT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      wr_q <= 1'b0;
      word_q <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      lat_cnt <= lat_nxt;
      if (state == IDLE && miss) begin
        wr_q <= req_write;
        word_q <= req_is_word;
      end
      if (state == RESOLVE && !cache_hit) err <= 1'b1;
    end
  end
  always_comb begin
    state_nxt = state;
    lat_nxt = lat_cnt;
    case (state)
      IDLE: begin
        state_nxt = miss ? (cache_dirty ? WB : FILL) : IDLE;
        lat_nxt = miss ? LW'(1) : lat_cnt;
      end
      WB: begin
        state_nxt = done ? FILL : WB;
        lat_nxt = done ? LW'(1) : lat_cnt + 1'b1;
      end
      FILL: begin
        state_nxt = done ? RESOLVE : FILL;
        lat_nxt = done ? '0 : lat_cnt + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        lat_nxt = '0;
      end
    endcase
  end
  always_comb begin
    acc_wr = (state == IDLE) ? req_write : wr_q;
    acc = (state == IDLE) ? hit : (state == RESOLVE);
    store_we = acc && acc_wr;
    fill_we = (state == FILL) && done;
    we_cache = !rst && (store_we || fill_we);
    cache_input_type = !rst && store_we;
    set_valid = we_cache;
    set_dirty = cache_input_type;
    we_memory = !rst && (state == WB) && done;
    memory_address_type = state == WB;
    register_write = acc && !acc_wr;
    busy = state != IDLE;
    lock = (state == IDLE) ? miss : (state != RESOLVE);
    pc_enable = !lock;
    is_word = busy ? word_q : req_is_word;
  end
`ifdef MEM_MISS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      wb_cnt <= '0;
    end else begin
      if (state == IDLE && hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
      if (state == IDLE && miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
      if (state == WB && done && !(&wb_cnt)) wb_cnt <= wb_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_miss_sequencer.sv
// tb_mem_miss_sequencer: randomized scoreboard bench for mem_miss_sequencer at MEM_LATENCY 4 and 1
module tb_mem_miss_sequencer;
  typedef struct packed {
    logic we_cache, cache_input_type, set_valid, set_dirty, we_memory, memory_address_type;
    logic is_word, register_write, lock, pc_enable, busy, err;
  } o_t;
  typedef struct {
    o_t o;
    int dut;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, req_valid = 1'b0, req_write = 1'b0, req_is_word = 1'b0, cache_hit = 1'b0, cache_dirty = 1'b0;
  o_t v0, v1, got;
  exp_t q[$];
  exp_t em;
  int n_chk = 0, n_fail = 0, cur_l = 4;
  logic err_m = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic wc, cit, sv, sd, wm, mat, iw, rw, lk, pe, bs, er;
    mem_miss_sequencer #(.MEM_LATENCY(g == 0 ? 4 : 1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_is_word(req_is_word), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
      .we_cache(wc), .cache_input_type(cit), .set_valid(sv), .set_dirty(sd),
      .we_memory(wm), .memory_address_type(mat), .is_word(iw), .register_write(rw),
      .lock(lk), .pc_enable(pe), .busy(bs), .err(er)
    );
    if (g == 0) begin : g_a
      assign v0 = {wc, cit, sv, sd, wm, mat, iw, rw, lk, pe, bs, er};
    end else begin : g_b
      assign v1 = {wc, cit, sv, sd, wm, mat, iw, rw, lk, pe, bs, er};
    end
  end
  always @(negedge clk) begin
    if (q.size() > 0) begin
      em = q.pop_front();
      got = (em.dut == 1) ? v1 : v0;
      n_chk++;
      if (got !== em.o) begin
        n_fail++;
        $display("FAIL %s dut%0d: got %b required %b (wc cit sv sd wm mat iw rw lk pe bs er)",
                 em.name, em.dut, got, em.o);
      end
    end
  end
  task automatic drive(input logic r, vl, w, wd, h, d, input o_t e, input string nm, input bit push);
    @(posedge clk);
    #1;
    rst = r;
    req_valid = vl;
    req_write = w;
    req_is_word = wd;
    cache_hit = h;
    cache_dirty = d;
    if (push) q.push_back('{e, (cur_l == 1) ? 1 : 0, nm});
  endtask
  task automatic idle(input logic r, input bit push);
    o_t e = '0;
    logic wd = r ? 1'b0 : 1'($urandom);
    e.pc_enable = 1'b1;
    e.is_word = wd;
    e.err = err_m;
    drive(r, 1'b0, 1'($urandom), wd, 1'($urandom), 1'($urandom), e, r ? "reset" : "idle", push);
    if (r) err_m = 1'b0;
  endtask
  task automatic txn(input logic w, wd, h, d, rh, input int rst_at, input string nm);
    int nw = d ? cur_l : 0;
    int r = nw + cur_l + 1;
    o_t e;
    if (h) begin
      e = '0;
      e.pc_enable = 1'b1;
      e.is_word = wd;
      e.err = err_m;
      e.register_write = !w;
      e.we_cache = w;
      e.cache_input_type = w;
      e.set_valid = w;
      e.set_dirty = w;
      drive(1'b0, 1'b1, w, wd, 1'b1, 1'($urandom), e, nm, 1'b1);
      return;
    end
    for (int k = 0; k <= r; k++) begin
      e = '0;
      e.busy = k > 0;
      e.lock = k < r;
      e.pc_enable = k == r;
      e.is_word = wd;
      e.err = err_m;
      e.memory_address_type = k >= 1 && k <= nw;
      e.we_memory = nw > 0 && k == nw;
      e.we_cache = k == nw + cur_l;
      e.set_valid = e.we_cache;
      if (k == r) begin
        e.register_write = !w;
        e.we_cache = w;
        e.cache_input_type = w;
        e.set_valid = w;
        e.set_dirty = w;
      end
      if (k == rst_at) begin
        e.we_cache = 1'b0;
        e.set_valid = 1'b0;
        e.set_dirty = 1'b0;
        e.cache_input_type = 1'b0;
        e.we_memory = 1'b0;
      end
      if (k == 0) drive(1'b0, 1'b1, w, wd, 1'b0, d, e, $sformatf("%s k%0d", nm, k), 1'b1);
      else drive(k == rst_at, 1'($urandom), 1'($urandom), 1'($urandom), (k == r) ? rh : 1'($urandom),
                 1'($urandom), e, $sformatf("%s k%0d", nm, k), 1'b1);
      if (k == rst_at) begin
        err_m = 1'b0;
        return;
      end
      if (k == r && !rh) err_m = 1'b1;
    end
  endtask
  task automatic rnd_txn();
    logic d = 1'($urandom);
    int ra = -1;
    if ($urandom_range(0, 7) == 0) ra = int'($urandom_range(1, d ? 2 * cur_l : cur_l));
    txn(1'($urandom), 1'($urandom), 1'($urandom), d, $urandom_range(0, 5) != 0, ra, "rnd");
  endtask
  initial begin
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    repeat (2) idle(1'b0, 1'b1);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, "load_hit");
    txn(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, "store_hit");
    txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, "clean_load_miss");
    txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, "dirty_store_miss");
    txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, "rst_mid_wb");
    idle(1'b0, 1'b1);
    txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cur_l, "rst_pending_wm");
    txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_l, "rst_pending_fill");
    txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "proto_err");
    repeat (3) idle(1'b0, 1'b1);
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) idle(1'b0, 1'b1);
      rnd_txn();
    end
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    cur_l = 1;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, "l1_dirty_store");
    txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, "l1_clean_load");
    txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, "l1_rst_pending_wm");
    txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, "l1_proto_err");
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    repeat (20) begin
      if ($urandom_range(0, 2) == 0) idle(1'b0, 1'b1);
      rnd_txn();
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_miss_sequencer.md
Name: mem_miss_sequencer

Overview:
- Multi-cycle controller that sequences the MEM-stage data cache and main memory for loads and stores.
- Hits complete in one cycle with no stall.
- Misses freeze the pipeline and run, in order: dirty write-back (if needed), line fill, then a resolve cycle that completes the original access.
- Drives the cache write and valid/dirty controls, the memory write enable and address select, and the pipeline stall signals `lock` and `pc_enable`.

Parameters:
- MEM_LATENCY, 4: main-memory access time in cycles; legal range 1..15.
- CNT_W, 16: width of the performance counters; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a load or store this cycle
- req_write  in  1  1 = store (sw/sb), 0 = load
- req_is_word  in  1  1 = word access, 0 = byte access
- cache_hit  in  1  tag match and valid for the current address
- cache_dirty  in  1  indexed line is dirty
- we_cache  out  1  cache write strobe
- cache_input_type  out  1  0 = fill data from memory, 1 = rt store data
- set_valid  out  1  valid bit value written with we_cache
- set_dirty  out  1  dirty bit value written with we_cache
- we_memory  out  1  memory write strobe
- memory_address_type  out  1  1 = write-back address from cache, 0 = ALU address
- is_word  out  1  access size presented to the cache
- register_write  out  1  load result may be written to the register file
- lock  out  1  pipeline freeze
- pc_enable  out  1  PC update permitted
- busy  out  1  state machine is not in IDLE
- err  out  1  sticky protocol error

Behaviour:
- States: IDLE, WB, FILL, RESOLVE. There is one latency counter `lat_cnt`, $clog2(MEM_LATENCY+1) bits wide.
- Reset (while rst=1 at the clock edge): state becomes IDLE, `lat_cnt` clears to 0, `err` clears to 0, latched request fields clear to 0.
- Outputs while rst is high and in IDLE with no request: pc_enable=1; every other output 0.
- IDLE with req_valid=0: outputs at their idle defaults.
- IDLE with req_valid=1 and cache_hit=1, load: register_write=1 in the same cycle; no stall.
- IDLE with req_valid=1 and cache_hit=1, store: in the same cycle we_cache=1, cache_input_type=1, set_valid=1, set_dirty=1.
- IDLE with req_valid=1 and cache_hit=0 (miss):
  - Combinationally in the same cycle: lock=1, pc_enable=0.
  - Latch req_write and req_is_word.
  - Next state is WB if cache_dirty=1, otherwise FILL; `lat_cnt` loads 1.
- WB:
  - memory_address_type=1 throughout.
  - we_memory=1 only on the cycle where lat_cnt==MEM_LATENCY; on that cycle go to FILL and load lat_cnt=1.
  - Otherwise increment lat_cnt.
- FILL:
  - memory_address_type=0.
  - On lat_cnt==MEM_LATENCY: we_cache=1, cache_input_type=0, set_valid=1, set_dirty=0, then go to RESOLVE.
- RESOLVE (one cycle):
  - Performs the latched access exactly as an IDLE hit would (load: register_write=1; store: cache write with set_dirty=1).
  - lock=0 and pc_enable=1 on this cycle; next state IDLE.
  - If cache_hit=0 here, set err=1. It stays 1 until reset.
- In all non-IDLE states other than RESOLVE: lock=1, pc_enable=0, busy=1.
- busy=1 in every non-IDLE state, including RESOLVE.
- is_word: the latched value while busy, otherwise req_is_word.
- Stall counts, with L=MEM_LATENCY:
  - Clean miss: pc_enable low for L+1 cycles; RESOLVE at cycle L+1 after detection.
  - Dirty miss: pc_enable low for 2L+1 cycles; RESOLVE at cycle 2L+1.
- Inputs during WB/FILL: req_valid, req_write, req_is_word and cache_dirty are ignored.
- Request in the RESOLVE cycle: a new request is not accepted; the next request is evaluated in IDLE on the following cycle.
- Reset mid-miss: return to IDLE at the next edge. A pending we_memory or we_cache pulse is not issued.
- MEM_LATENCY=1: WB and FILL each last exactly one cycle.

Optional Feature:
- Macro: MEM_MISS_PERF_EN.
- When defined, add outputs hit_cnt, miss_cnt and wb_cnt (each CNT_W bits).
  - hit_cnt increments on each IDLE hit.
  - miss_cnt increments on each miss detection.
  - wb_cnt increments on each WB→FILL transition.
  - All three saturate at all-ones and clear on rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req_valid=0 → pc_enable=1, all other outputs 0, busy=0.
- Load hit: req_valid=1, req_write=0, cache_hit=1 → register_write=1 the same cycle; lock never asserted.
- Clean load miss, L=4: cache_hit=0, cache_dirty=0 at cycle 0 → lock=1 for cycles 0–4; we_cache/set_valid pulse at cycle 4; at cycle 5 (RESOLVE, cache_hit=1) register_write=1 and pc_enable=1.
- Dirty store miss, L=4: cache_dirty=1 → memory_address_type=1 for cycles 1–4 with we_memory only at cycle 4; fill we_cache at cycle 8; RESOLVE at cycle 9 with we_cache=1, cache_input_type=1, set_dirty=1.
- Reset mid-WB: assert rst at cycle 2 of WB → state returns to IDLE next edge, we_memory never pulses, pc_enable=1.
- Protocol error: hold cache_hit=0 during RESOLVE → err=1 and remains 1 until the next rst.
